// File: rtl/nor_basic_gates.sv
// nor_basic_gates: the seven basic two-input logic functions of A and B,
// built as a network of 2-input NOR primitives and registered on one
// clock edge. Reset clears all outputs synchronously.
module nor_basic_gates (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  output logic y_not,
  output logic y_and,
  output logic y_or,
  output logic y_nand,
  output logic y_nor,
  output logic y_xor,
  output logic y_xnor
);

  logic n0;
  logic nb;
  logic n2;
  logic n3;
  logic y_not_c;
  logic y_and_c;
  logic y_or_c;
  logic y_nand_c;
  logic y_nor_c;
  logic y_xor_c;
  logic y_xnor_c;

  // Stage p0: NOR-only combinational network on the raw operands.
  nor g_n0    (n0,       A,        B);
  nor g_not_a (y_not_c,  A,        A);
  nor g_not_b (nb,       B,        B);
  nor g_or    (y_or_c,   n0,       n0);
  nor g_and   (y_and_c,  y_not_c,  nb);
  nor g_nand  (y_nand_c, y_and_c,  y_and_c);
  nor g_n2    (n2,       A,        n0);
  nor g_n3    (n3,       B,        n0);
  nor g_xnor  (y_xnor_c, n2,       n3);
  nor g_xor   (y_xor_c,  y_xnor_c, y_xnor_c);

  assign y_nor_c = n0;

  // Stage p1: capture every gate result; reset forces all outputs low.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_not  <= 1'b0;
      y_and  <= 1'b0;
      y_or   <= 1'b0;
      y_nand <= 1'b0;
      y_nor  <= 1'b0;
      y_xor  <= 1'b0;
      y_xnor <= 1'b0;
    end else begin
      y_not  <= y_not_c;
      y_and  <= y_and_c;
      y_or   <= y_or_c;
      y_nand <= y_nand_c;
      y_nor  <= y_nor_c;
      y_xor  <= y_xor_c;
      y_xnor <= y_xnor_c;
    end
  end

endmodule

// File: tb/tb_nor_basic_gates.sv
// Scoreboard bench for nor_basic_gates: the driver pushes the expected
// output vector for each edge, the monitor pops and compares after it.
module tb_nor_basic_gates;

  logic clk;
  logic rst;
  logic A;
  logic B;
  logic y_not;
  logic y_and;
  logic y_or;
  logic y_nand;
  logic y_nor;
  logic y_xor;
  logic y_xnor;

  typedef struct {
    logic [6:0] v;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  nor_basic_gates dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .y_not  (y_not),
    .y_and  (y_and),
    .y_or   (y_or),
    .y_nand (y_nand),
    .y_nor  (y_nor),
    .y_xor  (y_xor),
    .y_xnor (y_xnor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written truth table, ordering {not,and,or,nand,nor,xor,xnor}.
  function automatic logic [6:0] table_lookup(input logic a, input logic b);
    case ({a, b})
      2'b00:   table_lookup = 7'b1001101;
      2'b01:   table_lookup = 7'b1011010;
      2'b10:   table_lookup = 7'b0011010;
      default: table_lookup = 7'b0110001;
    endcase
  endfunction

  // Drive one cycle of stimulus before the next rising edge and queue the
  // response that edge must produce.
  task automatic apply(input logic a, input logic b, input logic r, input string tag);
    exp_t e;
    @(negedge clk);
    A   = a;
    B   = b;
    rst = r;
    e.v   = r ? 7'b0000000 : table_lookup(a, b);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Operands glitch during the low phase, settling before the edge.
  task automatic apply_glitch(input logic a, input logic b, input string tag);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    A = 1'b1; B = 1'b1; #1;
    A = 1'b0; B = 1'b0; #1;
    A = 1'b1; B = 1'b0; #1;
    A = a;    B = b;
    e.v   = table_lookup(a, b);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: after each rising edge, check the outputs against the oldest
  // queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t       e;
        logic [6:0] act;
        e   = exp_q.pop_front();
        act = {y_not, y_and, y_or, y_nand, y_nor, y_xor, y_xnor};
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s: got %b expected %b (not,and,or,nand,nor,xor,xnor)",
                   e.tag, act, e.v);
        end
      end
    end
  end

  initial begin
    A   = 1'b0;
    B   = 1'b0;
    rst = 1'b1;

    // Reset dominates even with both operands high.
    apply(1'b1, 1'b1, 1'b1, "reset_11");
    apply(1'b1, 1'b1, 1'b1, "reset_hold");

    // Directed truth table, one vector per cycle.
    apply(1'b0, 1'b0, 1'b0, "tt_00");
    apply(1'b0, 1'b1, 1'b0, "tt_01");
    apply(1'b1, 1'b0, 1'b0, "tt_10");
    apply(1'b1, 1'b1, 1'b0, "tt_11");

    // Steady 11, reset mid-run for one edge, then recovery.
    apply(1'b1, 1'b1, 1'b0, "steady_11");
    apply(1'b1, 1'b1, 1'b1, "mid_reset");
    apply(1'b1, 1'b1, 1'b0, "recover_11");
    apply(1'b0, 1'b0, 1'b0, "after_rec_00");

    // Glitches between edges must not leak into the outputs.
    apply_glitch(1'b0, 1'b1, "glitch_01");
    apply_glitch(1'b1, 1'b1, "glitch_11");
    apply_glitch(1'b0, 1'b0, "glitch_00");

    // Alternating inputs every cycle.
    for (int i = 0; i < 8; i++)
      apply(i[0], ~i[0], 1'b0, "alt");

    // Random 0/1 operands for 1000 cycles with occasional reset.
    for (int i = 0; i < 1000; i++) begin
      logic ra, rb, rr;
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 49) == 0);
      apply(ra, rb, rr, rr ? "rand_rst" : "rand");
    end

    // Drain with a bounded wait.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nor_basic_gates.md
NOR_BASIC_GATES -- requirements
Module: nor_basic_gates

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous reset, active-high, sampled on rising clk edge.
REQ-003 A  input  1  first gate operand.
REQ-004 B  input  1  second gate operand.
REQ-005 y_not  output  1  registered NOT A.
REQ-006 y_and  output  1  registered A AND B.
REQ-007 y_or  output  1  registered A OR B.
REQ-008 y_nand  output  1  registered NAND(A,B).
REQ-009 y_nor  output  1  registered NOR(A,B).
REQ-010 y_xor  output  1  registered A XOR B.
REQ-011 y_xnor  output  1  registered XNOR(A,B).
REQ-012 Port order: clk, rst, A, B, y_not, y_and, y_or, y_nand, y_nor, y_xor, y_xnor.
REQ-013 No parameters; all widths fixed at 1 bit.

Function
REQ-014 Combinational logic SHALL use only 2-input NOR primitives; no other operators or gate types in the logic cone.
REQ-015 NOR network: n0=NOR(A,B); y_nor_c=n0.
REQ-016 NOT: y_not_c=NOR(A,A); nb=NOR(B,B).
REQ-017 OR: y_or_c=NOR(n0,n0).
REQ-018 AND: y_and_c=NOR(y_not_c,nb).
REQ-019 NAND: y_nand_c=NOR(y_and_c,y_and_c).
REQ-020 XNOR: n2=NOR(A,n0); n3=NOR(B,n0); y_xnor_c=NOR(n2,n3).
REQ-021 XOR: y_xor_c=NOR(y_xnor_c,y_xnor_c).
REQ-022 Each output SHALL be a flip-flop loaded with its *_c value on every rising clk edge when rst=0.
REQ-023 Latency: exactly 1 clock from A/B sampled at edge k to outputs valid after edge k.
REQ-024 Outputs SHALL hold stable between clock edges regardless of A/B glitches.
REQ-025 Truth table after one edge (A,B -> not,and,or,nand,nor,xor,xnor): 00->1,0,0,1,1,0,1; 01->1,0,1,1,0,1,0; 10->0,0,1,1,0,1,0; 11->0,1,1,0,0,0,1.
REQ-026 Invariants at all non-reset cycles: y_nand=~y_and, y_nor=~y_or, y_xnor=~y_xor.
REQ-027 Inputs changing every cycle SHALL be tracked with no dropped or merged samples.
REQ-028 X/Z on A or B is not required to be handled; inputs are assumed driven 0/1.

Reset
REQ-029 With rst=1 at a rising edge, all seven outputs SHALL be 0 after that edge.
REQ-030 Reset dominates: A/B are ignored on any edge where rst=1.
REQ-031 Outputs remain 0 until the first edge with rst=0, after which REQ-022 applies.
REQ-032 Reset asserted mid-operation SHALL clear outputs at the next edge; no asynchronous effect between edges.
REQ-033 Power-up output value before first reset edge is undefined.

Verification
REQ-034 rst=1 one edge, A=1,B=1 -> all outputs 0 after edge.
REQ-035 rst=0, apply A,B = 00,01,10,11 one per cycle -> outputs match REQ-025 one cycle later each.
REQ-036 A=1,B=1 steady then rst=1 for one edge -> y_and goes 1->0 at that edge, returns to 1 one edge after rst=0.
REQ-037 A/B toggle between clock edges, then settle to A=0,B=1 before edge -> outputs reflect only 01 (y_xor=1, y_nor=0).
REQ-038 Exhaustive random 0/1 stimulus, 1000 cycles -> REQ-026 invariants and 1-cycle-delayed truth table hold every cycle.
REQ-039 Structural check: logic cone contains only 2-input NOR cells plus the seven output flops.
